// File: rtl/instr_prefetch.sv
// Instruction prefetch unit.
// Issues sequential fetches over a busy/ready memory handshake and keeps
// returned words, tagged with their addresses, in a small FIFO. A jump
// flushes the FIFO and drops any response that is still in flight.
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | one request outstanding, response will be kept
// DROP  | one request outstanding, response will be discarded
module instr_prefetch #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int PC_STEP = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_W-1:0]          fetch_addr,
  output logic                       fetch_req,
  input  logic                       e_mem_busy,
  input  logic                       e_mem_ready,
  input  logic [INSTR_W-1:0]         e_instr,
  output logic [INSTR_W-1:0]         instr_out,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic                       instr_valid,
  input  logic                       instr_take,
  input  logic                       jump,
  input  logic [ADDR_W-1:0]          jump_addr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [INSTR_W-1:0]  mem_instr [DEPTH];
  logic [ADDR_W-1:0]   mem_pc    [DEPTH];
  logic                accept;
  logic                push;
  logic                pop;

  // Request only when idle with a guaranteed free slot, so a push can never overflow.
  assign fetch_req   = (state == IDLE) && (count < CNT_W'(DEPTH)) && !rst;
  assign fetch_addr  = fetch_pc;
  assign accept      = fetch_req && !e_mem_busy;
  // A jump in the response cycle wins: the word belongs to the abandoned stream.
  assign push        = (state == WAIT) && e_mem_ready && !jump;
  assign pop         = instr_take && (count != '0) && !jump;
  assign instr_valid = (count != '0);
  // Head is read from registered storage, so a pushed word appears one cycle later.
  assign instr_out   = instr_valid ? mem_instr[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? mem_pc[rd_ptr]    : '0;

  // Fetch sequencing: outstanding-request state and the next fetch address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      if (jump) begin
        fetch_pc <= jump_addr;
      end else if (push) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      end
      case (state)
        IDLE: if (accept) state <= jump ? DROP : WAIT;
        WAIT: begin
          if (e_mem_ready)  state <= IDLE;
          else if (jump)    state <= DROP;
        end
        DROP: if (e_mem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; a jump empties the buffer.
  always_ff @(posedge clk) begin
    if (rst || jump) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_instr[wr_ptr] <= e_instr;
      mem_pc[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Testbench for instr_prefetch: directed scenarios followed by randomized
// traffic, all checked every cycle against a queue-based reference model.
module tb_instr_prefetch;

  logic        clk = 0;
  logic        rst;
  logic [15:0] fetch_addr;
  logic        fetch_req;
  logic        e_mem_busy;
  logic        e_mem_ready;
  logic [31:0] e_instr;
  logic [31:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_take;
  logic        jump;
  logic [15:0] jump_addr;
  logic [2:0]  count;

  instr_prefetch dut (
    .clk(clk), .rst(rst), .fetch_addr(fetch_addr), .fetch_req(fetch_req),
    .e_mem_busy(e_mem_busy), .e_mem_ready(e_mem_ready), .e_instr(e_instr),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_take(instr_take), .jump(jump), .jump_addr(jump_addr), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] pc;
  } entry_t;

  // reference model
  entry_t      m_q[$];
  logic [15:0] m_pc;
  bit          m_out;
  bit          m_drop;
  bit          cur_rst;

  // memory responder
  bit          mem_pending;
  int          mem_cnt;
  logic [31:0] mem_data;
  int          lat_min, lat_max;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_req();
    return !cur_rst && !m_out && (m_q.size() < 4);
  endfunction

  task automatic check_outputs();
    bit er;
    er = model_req();
    chk("fetch_req", fetch_req, er);
    if (er) chk("fetch_addr", fetch_addr, m_pc);
    chk("instr_valid", instr_valid, m_q.size() != 0);
    chk("count", count, m_q.size());
    if (m_q.size() != 0) begin
      chk("instr_pc", instr_pc, m_q[0].pc);
      chk("instr_out", instr_out, m_q[0].instr);
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), advance the model,
  // then check the DUT at the following negedge.
  task automatic cycle(input bit i_rst, input bit i_busy, input bit i_take,
                       input bit i_jump, input logic [15:0] i_jaddr, input bit i_extra);
    bit rdy, acc, pop;
    logic [31:0] dat;
    rdy = 0;
    dat = $urandom;
    acc = !i_rst && !m_out && (m_q.size() < 4) && !i_busy;
    if (i_rst) begin
      mem_pending = 0;
    end else if (mem_pending) begin
      if (mem_cnt == 0) begin
        rdy = 1;
        dat = mem_data;
        mem_pending = 0;
      end else begin
        mem_cnt--;
      end
    end else if (i_extra) begin
      rdy = 1;
    end
    rst = i_rst; e_mem_busy = i_busy; instr_take = i_take;
    jump = i_jump; jump_addr = i_jaddr; e_mem_ready = rdy; e_instr = dat;
    if (i_rst) begin
      m_q.delete(); m_pc = 16'h0000; m_out = 0; m_drop = 0;
    end else begin
      pop = i_take && (m_q.size() > 0) && !i_jump;
      if (pop) void'(m_q.pop_front());
      if (m_out && rdy) begin
        if (!m_drop && !i_jump) begin
          m_q.push_back('{instr: dat, pc: m_pc});
          m_pc = m_pc + 16'd1;
        end
        m_out = 0;
      end
      if (i_jump) begin
        m_q.delete();
        m_pc = i_jaddr;
        if (m_out) m_drop = 1;
      end
      if (acc) begin
        m_out = 1;
        m_drop = i_jump;
        mem_pending = 1;
        mem_cnt = $urandom_range(lat_min, lat_max) - 1;
        mem_data = $urandom;
      end
    end
    cur_rst = i_rst;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 16'h0, 0);
  endtask

  initial begin
    bit found, saw0;
    rst = 1; e_mem_busy = 0; e_mem_ready = 0; e_instr = 0;
    instr_take = 0; jump = 0; jump_addr = 0;
    cur_rst = 1; mem_pending = 0; mem_cnt = 0; mem_data = 0;
    m_pc = 0; m_out = 0; m_drop = 0;
    lat_min = 1; lat_max = 1;
    @(negedge clk);
    check_outputs();
    cycle(1, 0, 0, 0, 16'h0, 0);

    // fill with zero-wait memory, no takes
    idle(10);
    chk("fill_count", count, 3'd4);
    chk("fill_head_pc", instr_pc, 16'h0000);
    chk("fill_req_low", fetch_req, 1'b0);

    // one take refills at address 4
    cycle(0, 0, 1, 0, 16'h0, 0);
    idle(3);
    chk("take_head_pc", instr_pc, 16'h0001);
    chk("take_count", count, 3'd4);

    // busy held for 5 cycles while requesting
    cycle(0, 0, 1, 0, 16'h0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 16'h0, 0);
    chk("busy_addr", fetch_addr, 16'h0005);
    idle(3);

    // jump while WAIT drops the old response
    lat_min = 3; lat_max = 3;
    cycle(0, 0, 1, 0, 16'h0, 0);
    cycle(0, 0, 0, 0, 16'h0, 0);
    cycle(0, 0, 0, 1, 16'h0100, 0);
    lat_min = 1; lat_max = 1;
    idle(6);
    chk("jump_head_pc", instr_pc, 16'h0100);

    // jump + ready + take with count 2
    cycle(0, 0, 0, 1, 16'h0010, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_q.size() == 2 && mem_pending && mem_cnt == 0) found = 1;
      else idle(1);
    end
    chk("t6_setup", found, 1'b1);
    cycle(0, 0, 1, 1, 16'h0200, 0);
    chk("t6_count", count, 3'd0);
    chk("t6_addr", fetch_addr, 16'h0200);

    // address wrap
    cycle(0, 0, 0, 1, 16'hFFFF, 0);
    saw0 = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (fetch_req && fetch_addr == 16'h0000) saw0 = 1;
    end
    chk("wrap_fetch_0000", saw0, 1'b1);

    // reset while WAIT, then stray ready in IDLE
    lat_min = 3; lat_max = 3;
    cycle(0, 0, 0, 1, 16'h0040, 0);
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      if (m_out && !m_drop) found = 1;
      else idle(1);
    end
    chk("rst_setup", found, 1'b1);
    cycle(1, 0, 0, 0, 16'h0, 0);
    chk("rst_valid", instr_valid, 1'b0);
    cycle(0, 1, 0, 0, 16'h0, 1);
    chk("rst_ready_count", count, 3'd0);
    chk("rst_fetch_addr", fetch_addr, 16'h0000);

    // randomized traffic
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ja;
      ja = ($urandom_range(0, 3) == 0) ? (16'hFFFF - 16'($urandom_range(0, 2))) : 16'($urandom);
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0,
            ja,
            $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
